// File: rtl/hazard_fwd_unit.sv
// Decode-side hazard unit: per-operand bypass select with youngest-producer priority,
// long-latency register scoreboard, decode stall and a saturating stall-cycle counter.
module hazard_fwd_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      de_valid,
    input  logic [NUM_SRC*REG_AW-1:0]                 de_rs,
    input  logic [NUM_SRC-1:0]                        de_rs_used,
    input  logic [NUM_STAGES*REG_AW-1:0]              st_rd,
    input  logic [NUM_STAGES-1:0]                     st_wen,
    input  logic [NUM_STAGES-1:0]                     st_ready,
    input  logic                                      lat_issue,
    input  logic [REG_AW-1:0]                         lat_rd,
    input  logic                                      lat_done,
    input  logic [REG_AW-1:0]                         lat_done_rd,
    input  logic                                      lat_flush,
    output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]   fwd_sel,
    output logic                                      stall,
    output logic [CNT_W-1:0]                          stall_cnt
);
    localparam int SEL_W    = $clog2(NUM_STAGES + 1);
    localparam int NUM_REGS = 2 ** REG_AW;

    logic [NUM_REGS-1:0] sb_reg;
    logic [NUM_REGS-1:0] sb_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [NUM_SRC-1:0]  hazard;

    // Flush dominates; an issue after a done on the same rd leaves the new producer pending.
    always_comb begin
        sb_next = sb_reg;
        if (lat_flush) begin
            sb_next = '0;
        end else begin
            if (lat_done) begin
                sb_next[lat_done_rd] = 1'b0;
            end
            if (lat_issue && lat_rd != '0) begin
                sb_next[lat_rd] = 1'b1;
            end
        end
        sb_next[0] = 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] rs;
            logic [SEL_W-1:0]  sel;
            logic              hit;
            logic              hit_ready;

            assign rs = de_rs[gi*REG_AW +: REG_AW];

            // Scan oldest to youngest so the youngest matching stage is the last writer.
            always_comb begin
                sel       = '0;
                hit       = 1'b0;
                hit_ready = 1'b1;
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    if (st_wen[k] && st_rd[k*REG_AW +: REG_AW] == rs && rs != '0) begin
                        sel       = SEL_W'(k + 1);
                        hit       = 1'b1;
                        hit_ready = st_ready[k];
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = de_rs_used[gi] ? sel : '0;

            // A forwarding match shadows the scoreboard: the in-flight stage is the newer producer.
            assign hazard[gi] = de_valid && de_rs_used[gi] &&
                                (hit ? !hit_ready : (rs != '0 && sb_reg[rs]));
        end
    endgenerate

    assign stall     = |hazard;
    assign stall_cnt = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            sb_reg <= sb_next;
            if (stall && cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomized + directed bench for hazard_fwd_unit: stimulus pushes model results into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_fwd_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_valid;
    logic [9:0]  de_rs;
    logic [1:0]  de_rs_used;
    logic [9:0]  st_rd;
    logic [1:0]  st_wen;
    logic [1:0]  st_ready;
    logic        lat_issue;
    logic [4:0]  lat_rd;
    logic        lat_done;
    logic [4:0]  lat_done_rd;
    logic        lat_flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] stall_cnt;
    logic [3:0]  fwd_sel_s;
    logic        stall_s;
    logic [3:0]  stall_cnt_s;

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
        .st_rd(st_rd), .st_wen(st_wen), .st_ready(st_ready), .lat_issue(lat_issue),
        .lat_rd(lat_rd), .lat_done(lat_done), .lat_done_rd(lat_done_rd), .lat_flush(lat_flush),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_fwd_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs(de_rs), .de_rs_used(de_rs_used),
        .st_rd(st_rd), .st_wen(st_wen), .st_ready(st_ready), .lat_issue(lat_issue),
        .lat_rd(lat_rd), .lat_done(lat_done), .lat_done_rd(lat_done_rd), .lat_flush(lat_flush),
        .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs0;
        logic [1:0] used;
        logic [4:0] rd1, rd0;
        logic [1:0] wen, rdy;
        logic       iss;
        logic [4:0] ird;
        logic       dn;
        logic [4:0] drd;
        logic       fl;
    } stim_t;

    typedef struct {
        logic [3:0]  fsel;
        logic        stall;
        logic [31:0] cnt;
        logic [3:0]  sat;
    } exp_t;

    exp_t        q[$];
    int          pend[$];
    logic [31:0] m_cnt;
    logic [3:0]  m_sat;
    int          checks = 0;
    int          errors = 0;
    int          txn = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic bit is_pending(input int r);
        foreach (pend[j]) if (pend[j] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Reference outputs from the rules: youngest writer wins, x0 never forwarded,
    // an unready selected stage or a pending register with no in-flight writer stalls.
    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        int   rs[2];
        int   rd[2];
        e.fsel  = '0;
        e.stall = 1'b0;
        rs[0] = s.rs0; rs[1] = s.rs1;
        rd[0] = s.rd0; rd[1] = s.rd1;
        for (int i = 0; i < 2; i++) begin
            int src = 0;
            for (int k = 0; k < 2; k++) begin
                if (s.wen[k] && rd[k] == rs[i] && rs[i] != 0) begin
                    src = k + 1;
                    break;
                end
            end
            if (s.used[i]) begin
                e.fsel[i*2 +: 2] = 2'(src);
                if (s.v) begin
                    if (src != 0) begin
                        if (!s.rdy[src-1]) e.stall = 1'b1;
                    end else if (rs[i] != 0 && is_pending(rs[i])) begin
                        e.stall = 1'b1;
                    end
                end
            end
        end
        e.cnt = m_cnt;
        e.sat = m_sat;
        return e;
    endfunction

    function automatic void model_step(input stim_t s, input logic st);
        if (st && m_cnt != 32'hffff_ffff) m_cnt++;
        if (st && m_sat != 4'hf) m_sat++;
        if (s.fl) begin
            pend.delete();
        end else begin
            if (s.dn) begin
                for (int j = pend.size() - 1; j >= 0; j--) if (pend[j] == int'(s.drd)) pend.delete(j);
            end
            if (s.iss && s.ird != 0 && !is_pending(s.ird)) pend.push_back(s.ird);
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_cnt = '0;
        m_sat = '0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rd_ops(input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rs1 = rs1; s.rs0 = rs0; s.used = used;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        de_valid = s.v;      de_rs = {s.rs1, s.rs0};  de_rs_used = s.used;
        st_rd = {s.rd1, s.rd0}; st_wen = s.wen;     st_ready = s.rdy;
        lat_issue = s.iss;   lat_rd = s.ird;          lat_done = s.dn;
        lat_done_rd = s.drd; lat_flush = s.fl;
    endtask

    // One decode cycle: drive just after the edge, queue the expectation, advance the model
    // only if the coming edge is not held in reset.
    task automatic cyc(input stim_t s, input logic hold_rst = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = !hold_rst;
        apply(s);
        e = model_out(s);
        q.push_back(e);
        if (rst_n) model_step(s, e.stall);
    endtask

    // Assert reset between edges while a scoreboard stall is showing.
    task automatic reset_mid(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(s);
        e = model_out(s);
        #1;
        chk("pre_reset_stall", {31'b0, stall}, {31'b0, e.stall});
        chk("pre_reset_cnt", stall_cnt, e.cnt);
        rst_n = 1'b0;
        model_reset();
        #1;
        e = model_out(s);
        chk("async_reset_stall", {31'b0, stall}, {31'b0, e.stall});
        chk("async_reset_cnt", stall_cnt, 32'd0);
        chk("async_reset_sat", {28'b0, stall_cnt_s}, 32'd0);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            txn++;
            $display("txn %0d fwd_sel=%h stall=%0b stall_cnt=%0d sat=%0d", txn, fwd_sel, stall,
                     stall_cnt, stall_cnt_s);
            chk("fwd_sel", {28'b0, fwd_sel}, {28'b0, e.fsel});
            chk("stall", {31'b0, stall}, {31'b0, e.stall});
            chk("stall_cnt", stall_cnt, e.cnt);
            chk("sat_cnt", {28'b0, stall_cnt_s}, {28'b0, e.sat});
            chk("sat_stall", {31'b0, stall_s}, {31'b0, e.stall});
        end
    end

    initial begin
        stim_t s;
        model_reset();
        apply(idle());

        // Reset state, then activity under reset must leave no state behind.
        cyc(idle(), 1'b1);
        s = rd_ops(5'd5, 5'd5, 2'b11); s.iss = 1'b1; s.ird = 5'd7;
        cyc(s, 1'b1);
        cyc(rd_ops(5'd7, 5'd7, 2'b11));

        // EX and MEM both write x5: youngest wins.
        s = rd_ops(5'd5, 5'd5, 2'b11); s.rd1 = 5'd5; s.rd0 = 5'd5; s.wen = 2'b11; s.rdy = 2'b11;
        cyc(s);
        // x0 never forwarded; x7 from stage 1.
        s = rd_ops(5'd7, 5'd0, 2'b11); s.rd1 = 5'd7; s.rd0 = 5'd0; s.wen = 2'b11; s.rdy = 2'b11;
        cyc(s);
        s.used = 2'b01;
        cyc(s);

        // Load-use on x9, then the result becomes ready.
        s = rd_ops(5'd0, 5'd9, 2'b01); s.rd0 = 5'd9; s.wen = 2'b01; s.rdy = 2'b00;
        repeat (3) cyc(s);
        s.rdy = 2'b01;
        cyc(s);

        // Long-latency x12: four stalled reads, done cycle still stalls, clear after.
        s = idle(); s.iss = 1'b1; s.ird = 5'd12;
        cyc(s);
        repeat (4) cyc(rd_ops(5'd0, 5'd12, 2'b01));
        s = rd_ops(5'd0, 5'd12, 2'b01); s.dn = 1'b1; s.drd = 5'd12;
        cyc(s);
        cyc(rd_ops(5'd0, 5'd12, 2'b01));

        // Same-cycle done/issue on x3 keeps it pending; issue to x0 sets nothing.
        s = idle(); s.iss = 1'b1; s.ird = 5'd3; s.dn = 1'b1; s.drd = 5'd3;
        cyc(s);
        cyc(rd_ops(5'd3, 5'd0, 2'b10));
        s = idle(); s.dn = 1'b1; s.drd = 5'd3;
        cyc(s);
        s = idle(); s.iss = 1'b1; s.ird = 5'd0;
        cyc(s);
        cyc(rd_ops(5'd3, 5'd0, 2'b11));

        // Flush beats a same-cycle issue.
        s = idle(); s.iss = 1'b1; s.ird = 5'd20; cyc(s);
        s.ird = 5'd21; cyc(s);
        cyc(rd_ops(5'd21, 5'd20, 2'b11));
        s = idle(); s.fl = 1'b1; s.iss = 1'b1; s.ird = 5'd4; s.dn = 1'b1; s.drd = 5'd1;
        cyc(s);
        cyc(rd_ops(5'd21, 5'd20, 2'b11));
        cyc(rd_ops(5'd4, 5'd4, 2'b11));

        // Long load-use run saturates the narrow counter.
        s = rd_ops(5'd9, 5'd0, 2'b10); s.rd0 = 5'd9; s.wen = 2'b01; s.rdy = 2'b10;
        repeat (20) cyc(s);

        // Asynchronous reset in the middle of a scoreboard stall.
        s = idle(); s.iss = 1'b1; s.ird = 5'd12;
        cyc(s);
        cyc(rd_ops(5'd0, 5'd12, 2'b01));
        reset_mid(rd_ops(5'd0, 5'd12, 2'b01));
        cyc(rd_ops(5'd0, 5'd12, 2'b01));

        // Random traffic over a small register window to provoke matches.
        for (int n = 0; n < 400; n++) begin
            s.v    = ($urandom_range(0, 7) != 0);
            s.rs1  = 5'($urandom_range(0, 7));
            s.rs0  = 5'($urandom_range(0, 7));
            s.used = 2'($urandom_range(0, 3));
            s.rd1  = 5'($urandom_range(0, 7));
            s.rd0  = 5'($urandom_range(0, 7));
            s.wen  = 2'($urandom_range(0, 3));
            s.rdy  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            s.iss  = ($urandom_range(0, 3) == 0);
            s.ird  = 5'($urandom_range(0, 7));
            s.dn   = ($urandom_range(0, 2) == 0);
            s.drd  = 5'($urandom_range(0, 7));
            s.fl   = ($urandom_range(0, 29) == 0);
            cyc(s);
        end

        cyc(idle());
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
